// File: rtl/priority_encoder_drain.sv
// priority_encoder_drain: accepts a request vector and serves the index of each set bit,
// one per handshake beat, in priority order, clearing each bit as it is served.
module priority_encoder_drain #(
   parameter int N = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out,
   output logic         out_last,
   output logic         zero_in,
   output logic         busy
);
   typedef enum logic {IDLE, DRAIN} state_t;
   state_t state, state_nxt;
   logic [N-1:0] pend, pend_nxt;
   logic zero_nxt, accept, beat;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         pend    <= '0;
         zero_in <= 1'b0;
      end else begin
         state   <= state_nxt;
         pend    <= pend_nxt;
         zero_in <= zero_nxt;
      end
   // later matches overwrite earlier ones, so scan order picks the winning end
   always_comb begin
      out = '0;
      for (int i = 0; i < N; i++)
         if (pend[MSB_FIRST ? i : N-1-i]) out = W'(MSB_FIRST ? i : N-1-i);
   end
   assign out_last  = (pend != '0) && ((pend & (pend - N'(1))) == '0);
   assign out_valid = state == DRAIN;
   assign busy      = state == DRAIN;
   assign beat      = out_valid & out_ready;
   assign in_ready  = (state == IDLE) | (beat & out_last);
   assign accept    = in_valid & in_ready;
   // a vector accepted on the final beat replaces the (then empty) pending set directly
   always_comb begin
      pend_nxt  = accept ? in : beat ? pend & ~(N'(1) << out) : pend;
      state_nxt = pend_nxt != '0 ? DRAIN : IDLE;
      zero_nxt  = accept & ~|in;
   end
endmodule

// File: tb/tb_priority_encoder_drain.sv
// tb_priority_encoder_drain: runs MSB-first and LSB-first instances in lockstep against
// queue-based reference models, with directed scenarios followed by random traffic.
module tb_priority_encoder_drain;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [7:0] vec = '0;
   logic rm, vm, lm, zm, bm, rl, vl, ll, zl, bl;
   logic [2:0] om, ol;
   int n_chk = 0, n_fail = 0;
   int qm[$], ql[$];
   bit zexp = 1'b0;
   bit hold = 1'b0;
   always #5 clk = ~clk;
   priority_encoder_drain #(.N(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rm), .in(vec),
      .out_valid(vm), .out_ready(out_ready), .out(om), .out_last(lm), .zero_in(zm), .busy(bm));
   priority_encoder_drain #(.N(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rl), .in(vec),
      .out_valid(vl), .out_ready(out_ready), .out(ol), .out_last(ll), .zero_in(zl), .busy(bl));
   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit exp_ready();
      return qm.size() == 0 || (out_ready && qm.size() == 1);
   endfunction
   task automatic check_all();
      chk("m.valid", int'(vm), int'(qm.size() != 0));
      chk("m.busy", int'(bm), int'(qm.size() != 0));
      chk("m.out", int'(om), qm.size() != 0 ? qm[0] : 0);
      chk("m.last", int'(lm), int'(qm.size() == 1));
      chk("m.ready", int'(rm), int'(exp_ready()));
      chk("m.zero", int'(zm), int'(zexp));
      chk("l.valid", int'(vl), int'(ql.size() != 0));
      chk("l.out", int'(ol), ql.size() != 0 ? ql[0] : 0);
      chk("l.last", int'(ll), int'(ql.size() == 1));
      chk("l.ready", int'(rl), int'(ql.size() == 0 || (out_ready && ql.size() == 1)));
      chk("l.zero", int'(zl), int'(zexp));
      chk("l.busy", int'(bl), int'(ql.size() != 0));
   endtask
   // one cycle: drive at negedge, check, then advance the model across the rising edge
   task automatic step(input logic v, input logic [7:0] d, input logic r);
      bit acc;
      in_valid = v; vec = d; out_ready = r;
      #1;
      check_all();
      acc = v && exp_ready();
      hold = v && !acc;
      @(posedge clk);
      if (r && qm.size() != 0) begin
         void'(qm.pop_front());
         void'(ql.pop_front());
      end
      zexp = acc && d == 8'h00;
      if (acc && d != 8'h00) begin
         for (int i = 7; i >= 0; i--) if (d[i]) qm.push_back(i);
         for (int i = 0; i < 8; i++) if (d[i]) ql.push_back(i);
      end
      @(negedge clk);
   endtask
   initial begin
      logic [7:0] rv;
      logic rvalid;
      rv = '0; rvalid = 1'b0;
      #2;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 8'h80, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
      step(1, 8'hA6, 1); repeat (5) step(0, 8'h00, 1);
      step(1, 8'hA6, 1); step(0, 8'h00, 1);
      repeat (3) step(0, 8'h00, 0);
      repeat (4) step(0, 8'h00, 1);
      step(1, 8'h00, 1); step(0, 8'h00, 1); step(0, 8'h00, 1);
      step(1, 8'h03, 1); step(0, 8'h00, 1); step(1, 8'h10, 1);
      step(0, 8'h00, 1); step(0, 8'h00, 1);
      step(1, 8'h03, 1); step(0, 8'h00, 1); step(1, 8'h00, 1);
      step(0, 8'h00, 1); step(0, 8'h00, 1);
      step(1, 8'hA6, 1); step(0, 8'h00, 1); step(0, 8'h00, 0);
      chk("rst.pre_out", int'(ol), 2);
      rst_n = 1'b0;
      #1;
      chk("rst.m_valid", int'(vm), 0);
      chk("rst.l_valid", int'(vl), 0);
      chk("rst.l_busy", int'(bl), 0);
      qm.delete(); ql.delete(); zexp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 8'h00, 1);
      chk("rst.l_ready", int'(rl), 1);
      for (int c = 0; c < 400; c++) begin
         if (!hold) begin
            rvalid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
               0: rv = 8'h00;
               1: rv = 8'h01 << $urandom_range(0, 7);
               default: rv = 8'($urandom);
            endcase
         end
         step(rvalid, rv, 1'($urandom_range(0, 3) != 0));
      end
      repeat (12) step(0, 8'h00, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
